// File: rtl/bip_pkg.sv
// Shared definitions for the bip accumulator core: opcode values, FSM state encoding
// and the byte-count helper used to size the state dump.
package bip_pkg;

   localparam int unsigned OP_HLT  = 0;
   localparam int unsigned OP_STO  = 1;
   localparam int unsigned OP_LD   = 2;
   localparam int unsigned OP_LDI  = 3;
   localparam int unsigned OP_ADD  = 4;
   localparam int unsigned OP_ADDI = 5;
   localparam int unsigned OP_SUB  = 6;
   localparam int unsigned OP_SUBI = 7;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_WB     = 3'd3,
      S_DUMP   = 3'd4,
      S_DONE   = 3'd5
   } bip_state_e;

   function automatic int nbytes(input int w);
      return (w + 7) / 8;
   endfunction

endpackage

// File: rtl/bip_dump_serializer.sv
// Streams a loaded snapshot LSB byte first over valid/ready; pulses done_o one cycle
// after the last byte is accepted. tx_data_o only changes on an accepted byte.
module bip_dump_serializer #(
   parameter int NB   = 4,
   parameter int CNTW = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load_i,
   input  logic [8*NB-1:0] snap_i,
   input  logic [CNTW-1:0] nbytes_i,
   output logic [7:0]      tx_data_o,
   output logic            tx_valid_o,
   input  logic            tx_ready_i,
   output logic            done_o
);

   logic [8*NB-1:0] sh_q, sh_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            vld_q, vld_d;
   logic            done_q, done_d;

   always_comb begin
      sh_d   = sh_q;
      cnt_d  = cnt_q;
      vld_d  = vld_q;
      done_d = 1'b0;
      if (load_i) begin
         sh_d  = snap_i;
         cnt_d = nbytes_i;
         vld_d = 1'b1;
      end else if (vld_q && tx_ready_i) begin
         if (cnt_q == CNTW'(1)) begin
            vld_d  = 1'b0;
            done_d = 1'b1;
         end else begin
            sh_d  = sh_q >> 8;
            cnt_d = cnt_q - CNTW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sh_q   <= '0;
         cnt_q  <= '0;
         vld_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         sh_q   <= sh_d;
         cnt_q  <= cnt_d;
         vld_q  <= vld_d;
         done_q <= done_d;
      end
   end

   assign tx_data_o  = sh_q[7:0];
   assign tx_valid_o = vld_q;
   assign done_o     = done_q;

endmodule

// File: rtl/bip_core_dbg.sv
// Accumulator CPU core (FETCH/DECODE/EXEC/WB) that dumps ACC and PC as bytes on halt.
// Defining BIP_CYCLE_CNT_EN adds a saturating cycle counter appended to the dump.
module bip_core_dbg
   import bip_pkg::*;
#(
   parameter int AB  = 11,
   parameter int DB  = 16,
   parameter int OPW = 5,
   parameter int CW  = 32
) (
   input  logic          clk,
   input  logic          reset,
   output logic [AB-1:0] pm_addr,
   input  logic [DB-1:0] pm_data,
   output logic [AB-1:0] dm_addr,
   output logic [DB-1:0] dm_wdata,
   output logic          dm_we,
   output logic          dm_re,
   input  logic [DB-1:0] dm_rdata,
   input  logic          dbg_halt_req,
   output logic [7:0]    tx_data,
   output logic          tx_valid,
   input  logic          tx_ready,
   output logic          halted
);

   localparam int ACC_B = nbytes(DB);
   localparam int PC_B  = nbytes(AB);
`ifdef BIP_CYCLE_CNT_EN
   localparam int CYC_B = CW / 8;
`else
   localparam int CYC_B = 0;
`endif
   localparam int SNAP_B = ACC_B + PC_B + CYC_B;
   localparam int CNTW   = $clog2(SNAP_B + 1);

   bip_state_e          state_q, state_d;
   logic [AB-1:0]       pc_q, pc_d;
   logic [DB-1:0]       acc_q, acc_d;
   logic [OPW-1:0]      op_q, op_d;
   logic [AB-1:0]       opr_q, opr_d;
   logic [DB-1:0]       imm;
   logic                ser_load, ser_done;
   logic [8*SNAP_B-1:0] snap;

   assign imm      = {{(DB-AB){opr_q[AB-1]}}, opr_q};
   assign pm_addr  = pc_q;
   assign dm_wdata = acc_q;
   assign halted   = (state_q == S_DUMP) || (state_q == S_DONE);

`ifdef BIP_CYCLE_CNT_EN
   logic [CW-1:0] cyc_q, cyc_d;

   always_comb begin
      cyc_d = cyc_q;
      if (!halted && (cyc_q != '1)) cyc_d = cyc_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) cyc_q <= '0;
      else       cyc_q <= cyc_d;
   end
`endif

   // Snapshot is taken in the cycle that enters DUMP, so the counter includes that cycle.
   always_comb begin
      snap                 = '0;
      snap[DB-1:0]         = acc_q;
      snap[8*ACC_B +: AB]  = pc_q;
`ifdef BIP_CYCLE_CNT_EN
      snap[8*(ACC_B+PC_B) +: CW] = cyc_d;
`endif
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      acc_d    = acc_q;
      op_d     = op_q;
      opr_d    = opr_q;
      dm_we    = 1'b0;
      dm_re    = 1'b0;
      dm_addr  = '0;
      ser_load = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (dbg_halt_req) begin
               state_d  = S_DUMP;
               ser_load = 1'b1;
            end else begin
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            op_d    = pm_data[DB-1 -: OPW];
            opr_d   = pm_data[AB-1:0];
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            pc_d    = pc_q + 1'b1;
            case (op_q)
               OPW'(OP_HLT): begin
                  state_d  = S_DUMP;
                  pc_d     = pc_q;
                  ser_load = 1'b1;
               end
               OPW'(OP_STO): begin
                  dm_we   = 1'b1;
                  dm_addr = opr_q;
               end
               OPW'(OP_LD), OPW'(OP_ADD), OPW'(OP_SUB): begin
                  dm_re   = 1'b1;
                  dm_addr = opr_q;
                  state_d = S_WB;
                  pc_d    = pc_q;
               end
               OPW'(OP_LDI):  acc_d = imm;
               OPW'(OP_ADDI): acc_d = acc_q + imm;
               OPW'(OP_SUBI): acc_d = acc_q - imm;
               default: ;
            endcase
         end
         S_WB: begin
            state_d = S_FETCH;
            pc_d    = pc_q + 1'b1;
            case (op_q)
               OPW'(OP_LD):  acc_d = dm_rdata;
               OPW'(OP_ADD): acc_d = acc_q + dm_rdata;
               OPW'(OP_SUB): acc_d = acc_q - dm_rdata;
               default: ;
            endcase
         end
         S_DUMP: begin
            if (ser_done) state_d = S_DONE;
         end
         S_DONE: ;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         acc_q   <= '0;
         op_q    <= '0;
         opr_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         acc_q   <= acc_d;
         op_q    <= op_d;
         opr_q   <= opr_d;
      end
   end

   bip_dump_serializer #(
      .NB   (SNAP_B),
      .CNTW (CNTW)
   ) u_ser (
      .clk        (clk),
      .reset      (reset),
      .load_i     (ser_load),
      .snap_i     (snap),
      .nbytes_i   (CNTW'(SNAP_B)),
      .tx_data_o  (tx_data),
      .tx_valid_o (tx_valid),
      .tx_ready_i (tx_ready),
      .done_o     (ser_done)
   );

endmodule
